// File: rtl/draw_pixelgen_px.sv
// Pixel-generation engine: pops src/dst words, applies per-lane source transparency
// and a five-operand alpha blend, and pushes results to the write FIFO.
module draw_pixelgen_px #(
  parameter  int unsigned LANES = 2,
  parameter  int unsigned CW    = 8,
  localparam int unsigned PW    = 4 * CW,
  localparam int unsigned DW    = LANES * PW
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          INIT,
  input  logic          START,
  input  logic [15:0]   REG_COUNT,
  input  logic          REG_PATMODE,
  input  logic [PW-1:0] REG_FCOLOR,
  input  logic          REG_ST_ON,
  input  logic [3:0]    REG_SCOLOR_MASK,
  input  logic [PW-1:0] REG_SCOLOR_L,
  input  logic [PW-1:0] REG_SCOLOR_H,
  input  logic          REG_BLEND_ON,
  input  logic [2:0]    REG_SEL_A,
  input  logic [2:0]    REG_SEL_B,
  input  logic [2:0]    REG_SEL_C,
  input  logic [2:0]    REG_SEL_D,
  input  logic [2:0]    REG_SEL_E,
  input  logic [CW-1:0] REG_SRCCA,
  input  logic [PW-1:0] REG_COEF0,
  input  logic [PW-1:0] REG_COEF1,
  input  logic [DW-1:0] SRC_DATA,
  input  logic [DW-1:0] DST_DATA,
  input  logic          SRC_EMPTY,
  input  logic          DST_EMPTY,
  input  logic          WR_AFULL,
  output logic          SRC_RD,
  output logic          DST_RD,
  output logic          WR_WR,
  output logic [DW-1:0] PIXEL_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic [1:0]    ERROR
);

  localparam int unsigned SW = 2 * CW + 1;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] rem;
  logic        v1;
  logic        v2;
  logic        issue_c;

  // Stage-1 combinational results and their stage-2 registers
  logic [LANES-1:0]                trans_c, trans_q;
  logic [LANES-1:0][PW-1:0]        src_px_c, src_q;
  logic [LANES-1:0][PW-1:0]        dst_px_c, dst_q;
  logic [LANES-1:0][3:0][CW-1:0]   opa_c, opb_c, opc_c, opd_c, ope_c;
  logic [LANES-1:0][3:0][CW-1:0]   opa_q, opb_q, opc_q, opd_q, ope_q;
  logic [DW-1:0]                   src_w_c;
  logic [DW-1:0]                   pix_c;

  function automatic logic [CW-1:0] sel_op(
    input logic [2:0]    sel,
    input logic [CW-1:0] s_ch, d_ch, s_a, d_a, ca, c0, c1
  );
    logic [CW-1:0] r;
    case (sel)
      3'd0:    r = s_ch;
      3'd1:    r = d_ch;
      3'd2:    r = ca;
      3'd3:    r = s_a;
      3'd4:    r = d_a;
      3'd5:    r = c0;
      3'd6:    r = c1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue only with write credit and the needed FIFOs non-empty; INIT blocks pops
  assign issue_c = (state == ST_RUN) && !INIT && !WR_AFULL && !DST_EMPTY &&
                   (REG_PATMODE || !SRC_EMPTY);
  assign DST_RD  = issue_c;
  assign SRC_RD  = issue_c && !REG_PATMODE;

  // Job sequencer with registered BUSY/DONE/ERROR
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= ST_IDLE;
      rem   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERROR <= '0;
    end else if (INIT) begin
      state <= ST_IDLE;
      rem   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERROR <= '0;
    end else begin
      DONE <= 1'b0;
      if (START && BUSY) ERROR[0] <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (REG_COUNT == 16'd0) begin
              DONE     <= 1'b1;
              ERROR[1] <= 1'b1;
            end else begin
              rem   <= REG_COUNT;
              BUSY  <= 1'b1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue_c) begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last word is in the output stage once both inner valids are clear
          if (!v1 && !v2) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline valids: FIFO data present, operands registered, output written
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      WR_WR <= 1'b0;
    end else if (INIT) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      WR_WR <= 1'b0;
    end else begin
      v1    <= issue_c;
      v2    <= v1;
      WR_WR <= v2;
    end
  end

  // Stage 1: transparency key match and operand selection per lane/channel
  always_comb begin
    trans_c  = '0;
    src_px_c = '0;
    dst_px_c = '0;
    opa_c    = '0;
    opb_c    = '0;
    opc_c    = '0;
    opd_c    = '0;
    ope_c    = '0;
    src_w_c  = REG_PATMODE ? {LANES{REG_FCOLOR}} : SRC_DATA;
    for (int i = 0; i < LANES; i++) begin
      logic [PW-1:0] s_px;
      logic [PW-1:0] d_px;
      logic          key;
      s_px = src_w_c[DW-1-i*PW -: PW];
      d_px = DST_DATA[DW-1-i*PW -: PW];
      key  = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (REG_SCOLOR_MASK[c] &&
            ((s_px[c*CW +: CW] < REG_SCOLOR_L[c*CW +: CW]) ||
             (s_px[c*CW +: CW] > REG_SCOLOR_H[c*CW +: CW])))
          key = 1'b0;
        opa_c[i][c] = sel_op(REG_SEL_A, s_px[c*CW +: CW], d_px[c*CW +: CW], s_px[PW-1 -: CW],
                             d_px[PW-1 -: CW], REG_SRCCA, REG_COEF0[c*CW +: CW], REG_COEF1[c*CW +: CW]);
        opb_c[i][c] = sel_op(REG_SEL_B, s_px[c*CW +: CW], d_px[c*CW +: CW], s_px[PW-1 -: CW],
                             d_px[PW-1 -: CW], REG_SRCCA, REG_COEF0[c*CW +: CW], REG_COEF1[c*CW +: CW]);
        opc_c[i][c] = sel_op(REG_SEL_C, s_px[c*CW +: CW], d_px[c*CW +: CW], s_px[PW-1 -: CW],
                             d_px[PW-1 -: CW], REG_SRCCA, REG_COEF0[c*CW +: CW], REG_COEF1[c*CW +: CW]);
        opd_c[i][c] = sel_op(REG_SEL_D, s_px[c*CW +: CW], d_px[c*CW +: CW], s_px[PW-1 -: CW],
                             d_px[PW-1 -: CW], REG_SRCCA, REG_COEF0[c*CW +: CW], REG_COEF1[c*CW +: CW]);
        ope_c[i][c] = sel_op(REG_SEL_E, s_px[c*CW +: CW], d_px[c*CW +: CW], s_px[PW-1 -: CW],
                             d_px[PW-1 -: CW], REG_SRCCA, REG_COEF0[c*CW +: CW], REG_COEF1[c*CW +: CW]);
      end
      trans_c[i]  = REG_ST_ON && key;
      src_px_c[i] = s_px;
      dst_px_c[i] = d_px;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      trans_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      opd_q   <= '0;
      ope_q   <= '0;
    end else if (v1) begin
      trans_q <= trans_c;
      src_q   <= src_px_c;
      dst_q   <= dst_px_c;
      opa_q   <= opa_c;
      opb_q   <= opb_c;
      opc_q   <= opc_c;
      opd_q   <= opd_c;
      ope_q   <= ope_c;
    end
  end

  // Stage 2: saturating blend, then transparent/bypass selection
  always_comb begin
    pix_c = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [PW-1:0] blend_px;
      logic [PW-1:0] out_px;
      logic [SW-1:0] acc;
      blend_px = '0;
      out_px   = '0;
      acc      = '0;
      for (int c = 0; c < 4; c++) begin
        acc = SW'(opa_q[i][c]) * SW'(opb_q[i][c]) + SW'(opc_q[i][c]) * SW'(opd_q[i][c]);
        acc = (acc >> CW) + SW'(ope_q[i][c]);
        blend_px[c*CW +: CW] = (acc > SW'(CMAX)) ? CMAX : CW'(acc);
      end
      if (trans_q[i])        out_px = dst_q[i];
      else if (REG_BLEND_ON) out_px = blend_px;
      else                   out_px = src_q[i];
      pix_c[DW-1-i*PW -: PW] = out_px;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)  PIXEL_DATA <= '0;
    else if (INIT) PIXEL_DATA <= '0;
    else if (v2) PIXEL_DATA <= pix_c;
  end

endmodule

// File: tb/tb_draw_pixelgen_px.sv
// Directed bench for draw_pixelgen_px: FIFO models, an output monitor and
// one task per scenario with hand-computed expectations.
module tb_draw_pixelgen_px;

  localparam int unsigned LANES = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned PW    = 32;
  localparam int unsigned DW    = 64;

  logic          CLK, RST_X, INIT, START;
  logic [15:0]   REG_COUNT;
  logic          REG_PATMODE, REG_ST_ON, REG_BLEND_ON;
  logic [PW-1:0] REG_FCOLOR, REG_SCOLOR_L, REG_SCOLOR_H, REG_COEF0, REG_COEF1;
  logic [3:0]    REG_SCOLOR_MASK;
  logic [2:0]    REG_SEL_A, REG_SEL_B, REG_SEL_C, REG_SEL_D, REG_SEL_E;
  logic [CW-1:0] REG_SRCCA;
  logic [DW-1:0] SRC_DATA, DST_DATA;
  logic          SRC_EMPTY, DST_EMPTY, WR_AFULL;
  logic          SRC_RD, DST_RD, WR_WR, BUSY, DONE;
  logic [DW-1:0] PIXEL_DATA;
  logic [1:0]    ERROR;

  int n_assert = 0;
  int n_fail   = 0;

  // FIFO models: registered read data, pointers cleared by fifo_clr
  logic [DW-1:0] src_mem [0:127];
  logic [DW-1:0] dst_mem [0:127];
  int   src_len = 0, dst_len = 0, sp = 0, dp = 0;
  logic fifo_clr = 1'b0;
  logic src_hold = 1'b0;

  assign SRC_EMPTY = (sp >= src_len) || src_hold;
  assign DST_EMPTY = (dp >= dst_len);

  always @(posedge CLK) begin
    if (fifo_clr) begin
      sp <= 0;
      dp <= 0;
    end else begin
      if (SRC_RD) begin SRC_DATA <= src_mem[sp % 128]; sp <= sp + 1; end
      if (DST_RD) begin DST_DATA <= dst_mem[dp % 128]; dp <= dp + 1; end
    end
  end

  // Output monitor sampled on the falling edge
  int cyc = 0, dst_rd_cnt = 0, src_rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, viol = 0;
  logic busy_at_done = 1'b0;
  int   rd_cyc [0:1023];
  int   wr_cyc [0:1023];
  logic [DW-1:0] wr_log [0:1023];

  always @(negedge CLK) begin
    if (DST_RD) begin rd_cyc[dst_rd_cnt % 1024] = cyc; dst_rd_cnt++; end
    if (SRC_RD) src_rd_cnt++;
    if (WR_WR) begin
      wr_log[wr_cnt % 1024] = PIXEL_DATA;
      wr_cyc[wr_cnt % 1024] = cyc;
      wr_cnt++;
    end
    if (DONE) begin done_cnt++; done_cyc = cyc; busy_at_done = BUSY; end
    if ((DST_RD && (WR_AFULL || DST_EMPTY)) || (SRC_RD && (SRC_EMPTY || REG_PATMODE))) viol++;
    cyc++;
  end

  draw_pixelgen_px #(.LANES(LANES), .CW(CW)) dut (
    .CLK(CLK), .RST_X(RST_X), .INIT(INIT), .START(START), .REG_COUNT(REG_COUNT),
    .REG_PATMODE(REG_PATMODE), .REG_FCOLOR(REG_FCOLOR), .REG_ST_ON(REG_ST_ON),
    .REG_SCOLOR_MASK(REG_SCOLOR_MASK), .REG_SCOLOR_L(REG_SCOLOR_L), .REG_SCOLOR_H(REG_SCOLOR_H),
    .REG_BLEND_ON(REG_BLEND_ON), .REG_SEL_A(REG_SEL_A), .REG_SEL_B(REG_SEL_B),
    .REG_SEL_C(REG_SEL_C), .REG_SEL_D(REG_SEL_D), .REG_SEL_E(REG_SEL_E),
    .REG_SRCCA(REG_SRCCA), .REG_COEF0(REG_COEF0), .REG_COEF1(REG_COEF1),
    .SRC_DATA(SRC_DATA), .DST_DATA(DST_DATA), .SRC_EMPTY(SRC_EMPTY), .DST_EMPTY(DST_EMPTY),
    .WR_AFULL(WR_AFULL), .SRC_RD(SRC_RD), .DST_RD(DST_RD), .WR_WR(WR_WR),
    .PIXEL_DATA(PIXEL_DATA), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_defaults;
    INIT = 0; START = 0; REG_COUNT = 0; REG_PATMODE = 0; REG_FCOLOR = 0; REG_ST_ON = 0;
    REG_SCOLOR_MASK = 0; REG_SCOLOR_L = 0; REG_SCOLOR_H = 0; REG_BLEND_ON = 0;
    REG_SEL_A = 7; REG_SEL_B = 7; REG_SEL_C = 7; REG_SEL_D = 7; REG_SEL_E = 7;
    REG_SRCCA = 0; REG_COEF0 = 0; REG_COEF1 = 0; WR_AFULL = 0; src_hold = 0;
  endtask

  // Starts a job and waits (bounded) for its DONE pulse
  task automatic run_job(input int cnt, output bit ok);
    int d0;
    d0 = done_cnt;
    fifo_clr = 1; tick; fifo_clr = 0;
    REG_COUNT = 16'(cnt); START = 1; tick; START = 0;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      tick;
    end
  endtask

  // Single-word bitblt job; returns the written word
  task automatic run_one(input logic [DW-1:0] s, input logic [DW-1:0] d,
                         output logic [DW-1:0] got, output bit ok);
    int w0;
    bit jok;
    src_mem[0] = s; dst_mem[0] = d; src_len = 1; dst_len = 1;
    w0 = wr_cnt;
    run_job(1, jok);
    ok  = jok && (wr_cnt - w0 == 1);
    got = wr_log[w0 % 1024];
  endtask

  task automatic test_reset;
    set_defaults();
    RST_X = 0;
    repeat (3) @(posedge CLK);
    #1;
    n_assert++;
    if ({SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR} !== 7'b0 || PIXEL_DATA !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got ctl=%b pix=%h expected 0", {SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR}, PIXEL_DATA);
    end
    RST_X = 1; tick; tick;
    n_assert++;
    if ({SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR} !== 7'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got ctl=%b expected 0", {SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR});
    end
  endtask

  task automatic test_fill;
    int r0, s0, w0, d0;
    bit ok;
    set_defaults();
    REG_PATMODE = 1; REG_FCOLOR = 32'hFF102030;
    for (int i = 0; i < 4; i++) dst_mem[i] = 64'h0123456789ABCDEF + 64'(i);
    dst_len = 4; src_len = 0;
    r0 = dst_rd_cnt; s0 = src_rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    fifo_clr = 1; tick; fifo_clr = 0;
    REG_COUNT = 4; START = 1;
    n_assert++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL fill_busy_start: got %b expected 0", BUSY); end
    tick; START = 0;
    n_assert++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL fill_busy_rise: got %b expected 1", BUSY); end
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      tick;
    end
    tick; tick;
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL fill_done_timeout: got no DONE expected DONE"); end
    n_assert++;
    if (dst_rd_cnt - r0 != 4) begin n_fail++; $display("FAIL fill_dst_rd: got %0d expected 4", dst_rd_cnt - r0); end
    n_assert++;
    if (src_rd_cnt - s0 != 0) begin n_fail++; $display("FAIL fill_src_rd: got %0d expected 0", src_rd_cnt - s0); end
    n_assert++;
    if (wr_cnt - w0 != 4) begin n_fail++; $display("FAIL fill_wr_count: got %0d expected 4", wr_cnt - w0); end
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (wr_log[(w0 + k) % 1024] !== 64'hFF102030FF102030) begin
        n_fail++; $display("FAIL fill_data[%0d]: got %h expected ff102030ff102030", k, wr_log[(w0 + k) % 1024]);
      end
      n_assert++;
      if (wr_cyc[(w0 + k) % 1024] - rd_cyc[(r0 + k) % 1024] != 3) begin
        n_fail++; $display("FAIL fill_latency[%0d]: got %0d expected 3", k, wr_cyc[(w0 + k) % 1024] - rd_cyc[(r0 + k) % 1024]);
      end
      n_assert++;
      if (rd_cyc[(r0 + k) % 1024] - rd_cyc[r0 % 1024] != k) begin
        n_fail++; $display("FAIL fill_rd_spacing[%0d]: got %0d expected %0d", k, rd_cyc[(r0 + k) % 1024] - rd_cyc[r0 % 1024], k);
      end
    end
    n_assert++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL fill_done_count: got %0d expected 1", done_cnt - d0); end
    n_assert++;
    if (done_cyc != wr_cyc[(w0 + 3) % 1024] + 1) begin
      n_fail++; $display("FAIL fill_done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc[(w0 + 3) % 1024] + 1);
    end
    n_assert++;
    if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL fill_busy_at_done: got %b expected 0", busy_at_done); end
    n_assert++;
    if (ERROR !== 2'b00) begin n_fail++; $display("FAIL fill_error: got %b expected 00", ERROR); end
  endtask

  task automatic test_transparency;
    logic [DW-1:0] got;
    bit ok;
    set_defaults();
    REG_ST_ON = 1; REG_SCOLOR_MASK = 4'b0111;
    REG_SCOLOR_L = 32'h00FF00FF; REG_SCOLOR_H = 32'h00FF00FF;
    run_one({32'h80FF00FF, 32'h80112233}, {32'h11111111, 32'h22222222}, got, ok);
    n_assert++;
    if (!ok || got !== {32'h11111111, 32'h80112233}) begin
      n_fail++; $display("FAIL st_magenta_key: got %h ok=%0d expected 1111111180112233", got, ok);
    end
    REG_SCOLOR_MASK = 4'b0000;
    run_one({32'h80FF00FF, 32'h80112233}, {32'h11111111, 32'h22222222}, got, ok);
    n_assert++;
    if (!ok || got !== {32'h11111111, 32'h22222222}) begin
      n_fail++; $display("FAIL st_mask_zero: got %h ok=%0d expected 1111111122222222", got, ok);
    end
    REG_ST_ON = 0;
    run_one({32'h80FF00FF, 32'h80112233}, {32'h11111111, 32'h22222222}, got, ok);
    n_assert++;
    if (!ok || got !== {32'h80FF00FF, 32'h80112233}) begin
      n_fail++; $display("FAIL st_disabled: got %h ok=%0d expected 80ff00ff80112233", got, ok);
    end
  endtask

  task automatic test_blend;
    logic [DW-1:0] got;
    bit ok;
    set_defaults();
    REG_BLEND_ON = 1;
    REG_SEL_A = 0; REG_SEL_B = 3; REG_SEL_C = 1; REG_SEL_D = 5; REG_SEL_E = 7;
    REG_COEF0 = 32'h01010101;
    run_one({32'h80FF0000, 32'hFF804020}, 64'h0, got, ok);
    n_assert++;
    if (!ok || got !== {32'h407F0000, 32'hFE7F3F1F}) begin
      n_fail++; $display("FAIL blend_src_alpha: got %h ok=%0d expected 407f0000fe7f3f1f", got, ok);
    end
    REG_SEL_E = 6; REG_COEF1 = 32'hFFFFFFFF;
    run_one({32'h80FF0000, 32'hFF804020}, 64'h0, got, ok);
    n_assert++;
    if (!ok || got !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++; $display("FAIL blend_saturate: got %h ok=%0d expected ffffffffffffffff", got, ok);
    end
    REG_SEL_A = 1; REG_SEL_B = 2; REG_SEL_C = 7; REG_SEL_D = 7; REG_SEL_E = 0; REG_SRCCA = 8'h80;
    run_one({32'h01010101, 32'hFFFFFFFF}, {32'hFF804020, 32'h00000000}, got, ok);
    n_assert++;
    if (!ok || got !== {32'h80412111, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL blend_const_alpha: got %h ok=%0d expected 80412111ffffffff", got, ok);
    end
    // Dst times dst alpha on lane 0; lane 1 keyed transparent bypasses the blend
    REG_SEL_A = 7; REG_SEL_B = 7; REG_SEL_C = 1; REG_SEL_D = 4; REG_SEL_E = 7;
    REG_ST_ON = 1; REG_SCOLOR_MASK = 4'b0111;
    REG_SCOLOR_L = 32'h00FF00FF; REG_SCOLOR_H = 32'h00FF00FF;
    run_one({32'h80112233, 32'h80FF00FF}, {32'h80402010, 32'h12345678}, got, ok);
    n_assert++;
    if (!ok || got !== {32'h40201008, 32'h12345678}) begin
      n_fail++; $display("FAIL blend_dst_alpha_st: got %h ok=%0d expected 4020100812345678", got, ok);
    end
  endtask

  task automatic test_backpressure;
    int r0, s0, w0, d0, v0;
    bit ok;
    set_defaults();
    for (int i = 0; i < 100; i++) begin
      logic [31:0] hi;
      hi = 32'(i) * 32'd7 + 32'd1;
      src_mem[i] = {hi, 32'hC0DE0000 | 32'(i)};
      dst_mem[i] = ~src_mem[i];
    end
    src_len = 100; dst_len = 100;
    r0 = dst_rd_cnt; s0 = src_rd_cnt; w0 = wr_cnt; d0 = done_cnt; v0 = viol;
    fifo_clr = 1; tick; fifo_clr = 0;
    REG_COUNT = 100; START = 1; tick; START = 0;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      WR_AFULL = ($urandom_range(0, 2) == 0);
      src_hold = ($urandom_range(0, 2) == 0);
      if (done_cnt != d0) begin ok = 1; break; end
      tick;
    end
    WR_AFULL = 0; src_hold = 0;
    tick;
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got no DONE expected DONE"); end
    n_assert++;
    if (wr_cnt - w0 != 100) begin n_fail++; $display("FAIL bp_wr_count: got %0d expected 100", wr_cnt - w0); end
    for (int k = 0; k < 100; k++) begin
      n_assert++;
      if (wr_log[(w0 + k) % 1024] !== src_mem[k]) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, wr_log[(w0 + k) % 1024], src_mem[k]);
      end
    end
    n_assert++;
    if (viol != v0) begin n_fail++; $display("FAIL bp_illegal_reads: got %0d expected 0", viol - v0); end
    n_assert++;
    if (dst_rd_cnt - r0 != 100 || src_rd_cnt - s0 != 100) begin
      n_fail++; $display("FAIL bp_rd_counts: got dst=%0d src=%0d expected 100", dst_rd_cnt - r0, src_rd_cnt - s0);
    end
  endtask

  task automatic test_boundaries;
    int w0, d0, r0;
    bit ok;
    set_defaults();
    REG_COUNT = 0; START = 1; tick; START = 0;
    n_assert++;
    if (DONE !== 1'b1 || ERROR !== 2'b10 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL count0_done: got done=%b err=%b busy=%b expected 1 10 0", DONE, ERROR, BUSY);
    end
    tick;
    n_assert++;
    if (DONE !== 1'b0 || ERROR !== 2'b10) begin
      n_fail++; $display("FAIL count0_sticky: got done=%b err=%b expected 0 10", DONE, ERROR);
    end
    INIT = 1; tick; INIT = 0;
    n_assert++;
    if (ERROR !== 2'b00) begin n_fail++; $display("FAIL init_clears_error: got %b expected 00", ERROR); end
    REG_PATMODE = 1; REG_FCOLOR = 32'hA5A5A5A5;
    dst_len = 8;
    w0 = wr_cnt; d0 = done_cnt; r0 = dst_rd_cnt;
    fifo_clr = 1; tick; fifo_clr = 0;
    REG_COUNT = 4; START = 1; tick; START = 0; tick;
    START = 1; tick; START = 0;
    n_assert++;
    if (ERROR !== 2'b01) begin n_fail++; $display("FAIL start_busy_error: got %b expected 01", ERROR); end
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      tick;
    end
    repeat (10) tick;
    n_assert++;
    if (!ok || wr_cnt - w0 != 4 || done_cnt - d0 != 1 || dst_rd_cnt - r0 != 4) begin
      n_fail++; $display("FAIL start_busy_no_reload: got wr=%0d done=%0d rd=%0d ok=%0d expected 4 1 4 1", wr_cnt - w0, done_cnt - d0, dst_rd_cnt - r0, ok);
    end
    n_assert++;
    if (ERROR !== 2'b01) begin n_fail++; $display("FAIL start_busy_sticky: got %b expected 01", ERROR); end
    INIT = 1; tick; INIT = 0;
  endtask

  task automatic test_init;
    int w0, d0;
    bit ok;
    set_defaults();
    REG_PATMODE = 1; REG_FCOLOR = 32'h5A5A5A5A; dst_len = 10;
    fifo_clr = 1; tick; fifo_clr = 0;
    REG_COUNT = 10; START = 1; tick; START = 0;
    n_assert++;
    if (DST_RD !== 1'b1) begin n_fail++; $display("FAIL init_first_issue: got %b expected 1", DST_RD); end
    w0 = wr_cnt; d0 = done_cnt;
    tick; tick;
    INIT = 1; #1;
    n_assert++;
    if (DST_RD !== 1'b0) begin n_fail++; $display("FAIL init_blocks_rd: got %b expected 0", DST_RD); end
    tick; INIT = 0;
    repeat (10) tick;
    n_assert++;
    if (wr_cnt != w0 || done_cnt != d0) begin
      n_fail++; $display("FAIL init_no_wr_done: got wr=%0d done=%0d expected 0 0", wr_cnt - w0, done_cnt - d0);
    end
    n_assert++;
    if ({SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR} !== 7'b0 || PIXEL_DATA !== '0) begin
      n_fail++; $display("FAIL init_outputs_zero: got ctl=%b pix=%h expected 0", {SRC_RD, DST_RD, WR_WR, BUSY, DONE, ERROR}, PIXEL_DATA);
    end
    REG_FCOLOR = 32'h0F1E2D3C; dst_len = 2;
    w0 = wr_cnt;
    run_job(2, ok);
    tick; tick;
    n_assert++;
    if (!ok || wr_cnt - w0 != 2 || wr_log[(w0 + 1) % 1024] !== 64'h0F1E2D3C0F1E2D3C) begin
      n_fail++; $display("FAIL init_new_job: got wr=%0d data=%h ok=%0d expected 2 0f1e2d3c0f1e2d3c", wr_cnt - w0, wr_log[(w0 + 1) % 1024], ok);
    end
  endtask

  task automatic test_async_reset;
    int w0, d0;
    set_defaults();
    REG_PATMODE = 1; REG_FCOLOR = 32'h77777777; dst_len = 10;
    fifo_clr = 1; tick; fifo_clr = 0;
    w0 = wr_cnt; d0 = done_cnt;
    REG_COUNT = 10; START = 1; tick; START = 0; tick; tick;
    #2 RST_X = 0;
    #1;
    n_assert++;
    if (BUSY !== 1'b0 || WR_WR !== 1'b0 || PIXEL_DATA !== '0 || DST_RD !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_abort: got busy=%b wr=%b rd=%b pix=%h expected 0", BUSY, WR_WR, DST_RD, PIXEL_DATA);
    end
    tick; RST_X = 1;
    repeat (8) tick;
    n_assert++;
    if (done_cnt != d0 || wr_cnt - w0 > 1) begin
      n_fail++; $display("FAIL async_reset_quiet: got done=%0d wr=%0d expected 0 <=1", done_cnt - d0, wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_transparency();
    test_blend();
    test_backpressure();
    test_boundaries();
    test_init();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_pixelgen_px.md
# draw_pixelgen_px

Parametrised pixel-generation engine for the 2D drawing pipeline. It reads source and destination words from the read FIFOs, applies per-pixel source transparency and a five-operand alpha blend across `LANES` pixels per word, and writes the results to the write FIFO. It sits between the read-side FIFOs and the write FIFO, under the register block. It runs a word-counted job sequencer with non-stalling pipeline credit control and a sticky error report.

## Interface
Parameters:
- `LANES`, 2, pixels per data word (1–8)
- `CW`, 8, bits per colour channel; pixel is A,R,G,B, `PW=4*CW`, `DW=LANES*PW`

Ports:
- CLK  in  1  clock
- RST_X  in  1  reset, asynchronous, active-low
- INIT  in  1  synchronous clear of all state
- START  in  1  job start pulse
- REG_COUNT  in  16  words in job
- REG_PATMODE  in  1  1 = fill (src = REG_FCOLOR), 0 = bitblt
- REG_FCOLOR  in  PW  fill colour
- REG_ST_ON  in  1  source transparency enable
- REG_SCOLOR_MASK  in  4  channel compare enable {A,R,G,B}
- REG_SCOLOR_L / REG_SCOLOR_H  in  PW  inclusive per-channel limits
- REG_BLEND_ON  in  1  blend enable
- REG_SEL_A..REG_SEL_E  in  3 each  operand selects
- REG_SRCCA  in  CW  constant alpha
- REG_COEF0 / REG_COEF1  in  PW  constant operands
- SRC_DATA / DST_DATA  in  DW  FIFO read data, valid 1 cycle after RD
- SRC_EMPTY / DST_EMPTY  in  1  FIFO empty
- WR_AFULL  in  1  write FIFO has fewer than 4 free entries
- SRC_RD / DST_RD  out  1  combinational FIFO pops
- WR_WR  out  1  write strobe
- PIXEL_DATA  out  DW  write data
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle completion pulse
- ERROR  out  2  sticky: [0] START while busy, [1] REG_COUNT=0 started

## Operation
- Lane i occupies bits `[DW-1-i*PW -: PW]`, so lane 0 is in the MSBs. Channels are ordered A,R,G,B from MSB to LSB.
- FSM IDLE → RUN on START with REG_COUNT≠0, loading the remaining counter `rem=REG_COUNT`.
- START with REG_COUNT=0 stays IDLE, pulses DONE next cycle and sets ERROR[1].
- Issue condition in RUN: `!WR_AFULL && !DST_EMPTY && (REG_PATMODE || !SRC_EMPTY)`.
  - On issue, DST_RD=1 and SRC_RD=!REG_PATMODE; `rem` decrements.
  - Reads are never issued outside RUN.
- RUN → DRAIN when the issue with rem=1 occurs.
- DRAIN waits until the pipeline is empty (3 cycles after the last issue), then DONE=1 for one cycle → IDLE.
- START while BUSY is ignored and sets ERROR[0].
- Transparency per lane, when REG_ST_ON=1: the lane is transparent if every masked channel satisfies L≤ch≤H.
  - Mask=0000 makes every pixel transparent.
  - A transparent lane outputs its dst pixel unchanged and bypasses the blend.
- Operand select per channel: 0 src, 1 dst, 2 REG_SRCCA, 3 src alpha, 4 dst alpha, 5 COEF0 channel, 6 COEF1 channel, 7 zero.
- Blend per channel: `out = sat(((A*B + C*D) >> CW) + E)`.
  - Products are 2·CW bits; the sum is 2·CW+1 bits.
  - Saturation is to `2^CW-1`.
- With REG_BLEND_ON=0 the output is src, or dst for transparent lanes.
- Register inputs are sampled every cycle and must be held stable while BUSY.
- INIT: return to IDLE, clear the pipeline valids, `rem`, ERROR and PIXEL_DATA. No DONE is generated and no further WR_WR occurs.

## Timing
- Reset / INIT values: SRC_RD=DST_RD=0, WR_WR=0, PIXEL_DATA=0, BUSY=0, DONE=0, ERROR=0.
- Pipeline, from the issue cycle t:
  - t+1: capture FIFO data.
  - t+2: register transparency flags and selected operands.
  - t+3: register blended PIXEL_DATA and assert WR_WR.
- Latency from RD to WR_WR is 3 cycles; throughput is 1 word per cycle.
- The pipeline never stalls. WR_AFULL credit covers the 3 in-flight words.
- BUSY rises the cycle after START and falls with DONE.
- DONE occurs in the cycle after the final WR_WR.
- WR_AFULL or an empty FIFO holds the issue only; words already in flight still complete.
- Asynchronous reset mid-job aborts immediately, with the same effect as INIT.

## Test plan
- **Fill, blend off, LANES=2:** REG_FCOLOR=FF102030, COUNT=4.
  - Expect DST_RD ×4, SRC_RD never, 4 WR_WR each 3 cycles after its RD.
  - Expect PIXEL_DATA=FF102030FF102030.
  - Expect DONE once, BUSY cleared the same cycle.
- **Bitblt transparency:** MASK=0111, L=H=00FF00FF (pure magenta key, A excluded); src lanes {80FF00FF, 80112233}, dst {11111111, 22222222}.
  - Expect output {11111111, 80112233}.
- **Blend:** A=src, B=src alpha, C=dst, D=COEF0=01010101 (so D=1 in every channel), E=zero; src=80FF0000, dst=00000000.
  - Expect the channel values src·srcA>>8 + 0: R = (255·128)>>8 = 127, G = B = 0, A = (128·128)>>8 = 64, i.e. pixel 407F0000.
  - Saturation case: E=COEF1=FFFFFFFF gives FFFFFFFF.
- **Backpressure:** toggle WR_AFULL and SRC_EMPTY randomly during COUNT=100.
  - Expect exactly 100 WR_WR in order.
  - Expect no read while WR_AFULL=1 or a required FIFO is empty.
- **Boundaries:** START with COUNT=0 gives DONE next cycle and ERROR=10. START during BUSY sets ERROR[0] with no count reload.
- **INIT mid-job:** assert INIT 2 cycles after an issue.
  - Expect no WR_WR afterwards, no DONE, all outputs zero.
  - A new job then runs normally.
